// File: rtl/bp_fe_fetch_block_scan_if.sv
// ---------------------------------------------------------------------------
// bp_fe_fetch_block_scan_if
//   Bundles the fetch-block input channel, the redirect strobe and the scan
//   result channel of bp_fe_fetch_block_scan.
//
//   Modports:
//     slave  - the scanner's view: consumes fetch blocks, produces scan results
//     master - the surrounding frontend's view: drives fetch blocks and
//              redirect, consumes scan results
//
//   Signals:
//     redirect_i          frontend redirect/flush
//     fetch_v_i           fetch block valid
//     fetch_ready_and_o   block accepted when fetch_v_i & fetch_ready_and_o
//     fetch_pc_i          PC of first useful parcel
//     fetch_data_i        fetch_parcels_p x 16-bit parcels, parcel 0 lowest
//     scan_v_o            scan result valid
//     scan_ready_and_i    consumer accepts the scan result
//     scan_block_pc_o     block-aligned PC of the scanned block
//     scan_instr_v_o      per-slot instruction present
//     scan_instr_o        per-slot instruction (compressed in low 16 bits)
//     scan_compressed_o / scan_branch_o / scan_jal_o / scan_jalr_o /
//     scan_call_o / scan_ret_o   per-slot classification flags
//     scan_cf_v_o         some valid slot is a branch/jal/jalr
//     scan_cf_idx_o       lowest control-flow slot
//     scan_cf_tgt_o       PC-relative target of that slot (0 for jalr)
// ---------------------------------------------------------------------------
interface bp_fe_fetch_block_scan_if #(
    parameter int vaddr_width_p   = 39,
    parameter int fetch_parcels_p = 4
);
    localparam int idx_width_lp = $clog2(fetch_parcels_p);

    logic                            redirect_i;
    logic                            fetch_v_i;
    logic                            fetch_ready_and_o;
    logic [vaddr_width_p-1:0]        fetch_pc_i;
    logic [16*fetch_parcels_p-1:0]   fetch_data_i;

    logic                            scan_v_o;
    logic                            scan_ready_and_i;
    logic [vaddr_width_p-1:0]        scan_block_pc_o;
    logic [fetch_parcels_p-1:0]      scan_instr_v_o;
    logic [32*fetch_parcels_p-1:0]   scan_instr_o;
    logic [fetch_parcels_p-1:0]      scan_compressed_o;
    logic [fetch_parcels_p-1:0]      scan_branch_o;
    logic [fetch_parcels_p-1:0]      scan_jal_o;
    logic [fetch_parcels_p-1:0]      scan_jalr_o;
    logic [fetch_parcels_p-1:0]      scan_call_o;
    logic [fetch_parcels_p-1:0]      scan_ret_o;
    logic                            scan_cf_v_o;
    logic [idx_width_lp-1:0]         scan_cf_idx_o;
    logic [vaddr_width_p-1:0]        scan_cf_tgt_o;

    modport slave (
        input  redirect_i, fetch_v_i, fetch_pc_i, fetch_data_i, scan_ready_and_i,
        output fetch_ready_and_o, scan_v_o, scan_block_pc_o, scan_instr_v_o,
               scan_instr_o, scan_compressed_o, scan_branch_o, scan_jal_o,
               scan_jalr_o, scan_call_o, scan_ret_o, scan_cf_v_o,
               scan_cf_idx_o, scan_cf_tgt_o
    );

    modport master (
        output redirect_i, fetch_v_i, fetch_pc_i, fetch_data_i, scan_ready_and_i,
        input  fetch_ready_and_o, scan_v_o, scan_block_pc_o, scan_instr_v_o,
               scan_instr_o, scan_compressed_o, scan_branch_o, scan_jal_o,
               scan_jalr_o, scan_call_o, scan_ret_o, scan_cf_v_o,
               scan_cf_idx_o, scan_cf_tgt_o
    );
endinterface

// File: rtl/bp_fe_fetch_block_scan.sv
// ---------------------------------------------------------------------------
// bp_fe_fetch_block_scan
//   Scans an aligned fetch block of fetch_parcels_p 16-bit parcels, finds
//   instruction boundaries across mixed RVC/32-bit code, carries the low half
//   of a 32-bit instruction straddling into the next block, and registers
//   per-slot control-flow classification plus the first control-flow slot and
//   its PC-relative target. One output register stage, full throughput.
//
//   Ports:
//     clk_i      clock
//     reset_n_i  asynchronous active-low reset
//     bus        bp_fe_fetch_block_scan_if.slave (fetch in, redirect, scan out)
// ---------------------------------------------------------------------------
module bp_fe_fetch_block_scan #(
    parameter int vaddr_width_p   = 39,
    parameter int fetch_parcels_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_fe_fetch_block_scan_if.slave  bus
);
    localparam int idx_width_lp = $clog2(fetch_parcels_p);
    localparam int P            = fetch_parcels_p;
    localparam int V            = vaddr_width_p;

    // Registered state
    logic               scan_v_r;
    logic [V-1:0]       block_pc_r;
    logic [32*P-1:0]    instr_r;
    logic [P-1:0]       instr_v_r, compressed_r, branch_r, jal_r, jalr_r, call_r, ret_r;
    logic               cf_v_r;
    logic [idx_width_lp-1:0] cf_idx_r;
    logic [V-1:0]       cf_tgt_r;
    logic               residual_v_r;
    logic [V-1:0]       residual_pc_r;
    logic [15:0]        residual_lo_r;

    // Combinational next values
    logic               fetch_ready;
    logic               accept;
    logic               splice;
    logic [V-1:0]       block_pc;
    int unsigned        walk_start;
    logic [16*P+15:0]   data_ext;
    logic [32*P-1:0]    instr_n;
    logic [P-1:0]       instr_v_n, compressed_n, branch_n, jal_n, jalr_n, call_n, ret_n;
    logic               cf_v_n;
    logic [idx_width_lp-1:0] cf_idx_n;
    logic [V-1:0]       cf_tgt_n;
    logic               res_v_n;
    logic [V-1:0]       res_pc_n;
    logic [15:0]        res_lo_n;

    assign fetch_ready = reset_n_i & ~bus.redirect_i & (~scan_v_r | bus.scan_ready_and_i);
    assign accept      = bus.fetch_v_i & fetch_ready;
    assign splice      = residual_v_r & (bus.fetch_pc_i == residual_pc_r + V'(2));
    // Zero parcel above the block keeps the upper-half select in range for
    // the last parcel; that path is never taken there.
    assign data_ext    = {16'h0000, bus.fetch_data_i};

    always_comb begin
        block_pc = bus.fetch_pc_i;
        block_pc[idx_width_lp:0] = '0;
        walk_start = splice ? 32'd1 : 32'(bus.fetch_pc_i[idx_width_lp:1]);
    end

    // Boundary walk: 'hi' marks a parcel that is the upper half of the
    // previous 32-bit instruction and therefore starts no slot.
    always_comb begin
        logic        hi;
        logic [15:0] parcel;
        instr_n      = '0;
        instr_v_n    = '0;
        compressed_n = '0;
        res_v_n      = 1'b0;
        res_pc_n     = '0;
        res_lo_n     = '0;
        hi           = 1'b0;
        parcel       = '0;
        if (splice) begin
            instr_v_n[0]   = 1'b1;
            instr_n[31:0]  = {data_ext[15:0], residual_lo_r};
        end
        for (int unsigned i = 0; i < P; i++) begin
            parcel = data_ext[16*i +: 16];
            if (hi) begin
                hi = 1'b0;
            end else if (i >= walk_start) begin
                if (parcel[1:0] != 2'b11) begin
                    instr_v_n[i]        = 1'b1;
                    compressed_n[i]     = 1'b1;
                    instr_n[32*i +: 32] = {16'h0000, parcel};
                end else if (i == P-1) begin
                    res_v_n  = 1'b1;
                    res_pc_n = block_pc + V'(2*i);
                    res_lo_n = parcel;
                end else begin
                    instr_v_n[i]        = 1'b1;
                    instr_n[32*i +: 32] = {data_ext[16*(i+1) +: 16], parcel};
                    hi                  = 1'b1;
                end
            end
        end
    end

    // Per-slot classification and first control-flow slot selection
    always_comb begin
        logic [31:0]  w;
        logic [V-1:0] imm;
        logic [V-1:0] pc;
        branch_n = '0;
        jal_n    = '0;
        jalr_n   = '0;
        call_n   = '0;
        ret_n    = '0;
        cf_v_n   = 1'b0;
        cf_idx_n = '0;
        cf_tgt_n = '0;
        for (int unsigned i = 0; i < P; i++) begin
            w   = instr_n[32*i +: 32];
            imm = '0;
            pc  = (splice && i == 0) ? residual_pc_r : block_pc + V'(2*i);
            if (instr_v_n[i]) begin
                if (compressed_n[i]) begin
                    if (w[1:0] == 2'b01 && w[15:14] == 2'b11) begin
                        branch_n[i] = 1'b1;
                        imm = {{(V-9){w[12]}}, w[12], w[6:5], w[2], w[11:10], w[4:3], 1'b0};
                    end else if (w[1:0] == 2'b01 && w[15:13] == 3'b101) begin
                        jal_n[i] = 1'b1;
                        imm = {{(V-12){w[12]}}, w[12], w[8], w[10:9], w[6], w[7], w[2],
                               w[11], w[5:3], 1'b0};
                    end else if (w[1:0] == 2'b10 && w[15:13] == 3'b100 &&
                                 w[6:2] == 5'd0 && w[11:7] != 5'd0) begin
                        jalr_n[i] = 1'b1;
                        if (!w[12]) begin
                            ret_n[i] = (w[11:7] == 5'd1) || (w[11:7] == 5'd5);
                        end else begin
                            call_n[i] = 1'b1;
                            ret_n[i]  = (w[11:7] == 5'd5);
                        end
                    end
                end else begin
                    case (w[6:0])
                        7'b1100011: begin
                            branch_n[i] = 1'b1;
                            imm = {{(V-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                        end
                        7'b1101111: begin
                            jal_n[i]  = 1'b1;
                            call_n[i] = (w[11:7] == 5'd1) || (w[11:7] == 5'd5);
                            imm = {{(V-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                        end
                        7'b1100111: begin
                            jalr_n[i] = 1'b1;
                            call_n[i] = (w[11:7] == 5'd1) || (w[11:7] == 5'd5);
                            ret_n[i]  = ((w[19:15] == 5'd1) || (w[19:15] == 5'd5)) &&
                                        (w[11:7] != w[19:15]);
                        end
                        default: ;
                    endcase
                end
            end
            if (!cf_v_n && (branch_n[i] || jal_n[i] || jalr_n[i])) begin
                cf_v_n   = 1'b1;
                cf_idx_n = idx_width_lp'(i);
                cf_tgt_n = jalr_n[i] ? '0 : pc + imm;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scan_v_r      <= 1'b0;
            block_pc_r    <= '0;
            instr_r       <= '0;
            instr_v_r     <= '0;
            compressed_r  <= '0;
            branch_r      <= '0;
            jal_r         <= '0;
            jalr_r        <= '0;
            call_r        <= '0;
            ret_r         <= '0;
            cf_v_r        <= 1'b0;
            cf_idx_r      <= '0;
            cf_tgt_r      <= '0;
            residual_v_r  <= 1'b0;
            residual_pc_r <= '0;
            residual_lo_r <= '0;
        end else if (bus.redirect_i) begin
            scan_v_r     <= 1'b0;
            residual_v_r <= 1'b0;
        end else if (accept) begin
            scan_v_r      <= 1'b1;
            block_pc_r    <= block_pc;
            instr_r       <= instr_n;
            instr_v_r     <= instr_v_n;
            compressed_r  <= compressed_n;
            branch_r      <= branch_n;
            jal_r         <= jal_n;
            jalr_r        <= jalr_n;
            call_r        <= call_n;
            ret_r         <= ret_n;
            cf_v_r        <= cf_v_n;
            cf_idx_r      <= cf_idx_n;
            cf_tgt_r      <= cf_tgt_n;
            residual_v_r  <= res_v_n;
            residual_pc_r <= res_pc_n;
            residual_lo_r <= res_lo_n;
        end else if (bus.scan_ready_and_i) begin
            scan_v_r <= 1'b0;
        end
    end

    assign bus.fetch_ready_and_o = fetch_ready;
    assign bus.scan_v_o          = scan_v_r;
    assign bus.scan_block_pc_o   = block_pc_r;
    assign bus.scan_instr_v_o    = instr_v_r;
    assign bus.scan_instr_o      = instr_r;
    assign bus.scan_compressed_o = compressed_r;
    assign bus.scan_branch_o     = branch_r;
    assign bus.scan_jal_o        = jal_r;
    assign bus.scan_jalr_o       = jalr_r;
    assign bus.scan_call_o       = call_r;
    assign bus.scan_ret_o        = ret_r;
    assign bus.scan_cf_v_o       = cf_v_r;
    assign bus.scan_cf_idx_o     = cf_idx_r;
    assign bus.scan_cf_tgt_o     = cf_tgt_r;
endmodule

// File: tb/tb_bp_fe_fetch_block_scan.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_fetch_block_scan
//   Directed bench for bp_fe_fetch_block_scan (P=4, vaddr 39). Expected scan
//   results are queued when a block is driven and compared when the DUT
//   presents its registered result.
// ---------------------------------------------------------------------------
module tb_bp_fe_fetch_block_scan;
    localparam int V = 39;
    localparam int P = 4;

    typedef struct {
        logic [127:0] instr;
        logic [3:0]   v, c, br, jal, jalr, call, ret;
        logic         cf_v;
        logic [1:0]   cf_idx;
        logic [V-1:0] cf_tgt;
        logic [V-1:0] bpc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    bp_fe_fetch_block_scan_if #(.vaddr_width_p(V), .fetch_parcels_p(P)) bus ();

    bp_fe_fetch_block_scan #(.vaddr_width_p(V), .fetch_parcels_p(P)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [127:0] instr, input logic [3:0] v, c, br, jal,
                                jalr, call, ret, input logic cf_v, input logic [1:0] idx,
                                input logic [V-1:0] tgt, input logic [V-1:0] bpc);
        exp_t e;
        e.instr = instr; e.v = v; e.c = c; e.br = br; e.jal = jal; e.jalr = jalr;
        e.call = call; e.ret = ret; e.cf_v = cf_v; e.cf_idx = idx; e.cf_tgt = tgt; e.bpc = bpc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_front(input bit pop);
        exp_t e;
        if (q.size() == 0) begin
            chk("queue_nonempty", 128'(q.size()), 128'd1);
            return;
        end
        e = q[0];
        if (pop) void'(q.pop_front());
        chk("scan_v",     128'(bus.scan_v_o),          128'd1);
        chk("block_pc",   128'(bus.scan_block_pc_o),   128'(e.bpc));
        chk("instr",      bus.scan_instr_o,            e.instr);
        chk("instr_v",    128'(bus.scan_instr_v_o),    128'(e.v));
        chk("compressed", 128'(bus.scan_compressed_o), 128'(e.c));
        chk("branch",     128'(bus.scan_branch_o),     128'(e.br));
        chk("jal",        128'(bus.scan_jal_o),        128'(e.jal));
        chk("jalr",       128'(bus.scan_jalr_o),       128'(e.jalr));
        chk("call",       128'(bus.scan_call_o),       128'(e.call));
        chk("ret",        128'(bus.scan_ret_o),        128'(e.ret));
        chk("cf_v",       128'(bus.scan_cf_v_o),       128'(e.cf_v));
        chk("cf_idx",     128'(bus.scan_cf_idx_o),     128'(e.cf_idx));
        chk("cf_tgt",     128'(bus.scan_cf_tgt_o),     128'(e.cf_tgt));
    endtask

    // Present a block and wait (bounded) until it is accepted on the next edge.
    task automatic drive(input logic [V-1:0] pc, input logic [63:0] data);
        int n;
        bus.fetch_v_i    = 1'b1;
        bus.fetch_pc_i   = pc;
        bus.fetch_data_i = data;
        #1;
        n = 0;
        while (bus.fetch_ready_and_o !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("fetch_ready", 128'(bus.fetch_ready_and_o), 128'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_scan_v"},   128'(bus.scan_v_o),          128'd0);
        chk({tag, "_ready"},    128'(bus.fetch_ready_and_o), 128'd0);
        chk({tag, "_instr"},    bus.scan_instr_o,            128'd0);
        chk({tag, "_instr_v"},  128'(bus.scan_instr_v_o),    128'd0);
        chk({tag, "_block_pc"}, 128'(bus.scan_block_pc_o),   128'd0);
        chk({tag, "_cf_v"},     128'(bus.scan_cf_v_o),       128'd0);
        chk({tag, "_cf_tgt"},   128'(bus.scan_cf_tgt_o),     128'd0);
    endtask

    localparam logic [127:0] NOP4  = {32'h1, 32'h1, 32'h1, 32'h1};
    localparam logic [127:0] NOP3Z = {32'h1, 32'h1, 32'h1, 32'h0};

    initial begin
        reset_n              = 1'b0;
        bus.redirect_i       = 1'b0;
        bus.fetch_v_i        = 1'b0;
        bus.fetch_pc_i       = '0;
        bus.fetch_data_i     = '0;
        bus.scan_ready_and_i = 1'b1;

        #3;
        check_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", 128'(bus.fetch_ready_and_o), 128'd1);

        // Four c.nop
        @(negedge clk);
        drive(39'h80000000, 64'h0001_0001_0001_0001);
        q.push_back(mk(NOP4, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, '0, 39'h80000000));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // jal x1,+8 ; c.jr x1 ; c.nop
        @(negedge clk);
        drive(39'h80000000, 64'h0001_8082_0080_00EF);
        q.push_back(mk({32'h1, 32'h8082, 32'h0, 32'h008000EF}, 4'b1101, 4'b1100, 0, 4'b0001,
                       4'b0100, 4'b0001, 4'b0100, 1, 0, 39'h80000008, 39'h80000000));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // Straddling beq, back-to-back blocks with splice
        @(negedge clk);
        drive(39'h80000000, 64'h0463_0001_0001_0001);
        q.push_back(mk({32'h0, 32'h1, 32'h1, 32'h1}, 4'b0111, 4'b0111, 0, 0, 0, 0, 0,
                       0, 0, '0, 39'h80000000));
        @(negedge clk);
        check_front(1);
        drive(39'h80000008, 64'h0001_0001_0001_0000);
        q.push_back(mk({32'h1, 32'h1, 32'h1, 32'h00000463}, 4'b1111, 4'b1110, 4'b0001, 0,
                       0, 0, 0, 1, 0, 39'h8000000E, 39'h80000008));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // Mid-block start parcel
        @(negedge clk);
        drive(39'h80000004, 64'h0001_0001_0001_0001);
        q.push_back(mk({32'h1, 32'h1, 32'h0, 32'h0}, 4'b1100, 4'b1100, 0, 0, 0, 0, 0,
                       0, 0, '0, 39'h80000000));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // RVC mix (c.ebreak, c.beqz -4, c.jalr x5, c.j +16) then jalr x0,0(x1)
        @(negedge clk);
        drive(39'h80000020, 64'hA801_9282_DC75_9002);
        q.push_back(mk({32'hA801, 32'h9282, 32'hDC75, 32'h9002}, 4'b1111, 4'b1111, 4'b0010,
                       4'b1000, 4'b0100, 4'b0100, 4'b0100, 1, 1, 39'h8000001E, 39'h80000020));
        @(negedge clk);
        check_front(1);
        drive(39'h80000040, 64'h0001_0001_0000_8067);
        q.push_back(mk({32'h1, 32'h1, 32'h0, 32'h00008067}, 4'b1101, 4'b1100, 0, 0,
                       4'b0001, 0, 4'b0001, 1, 0, '0, 39'h80000040));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // Redirect with a pending residual and an unconsumed result
        @(negedge clk);
        drive(39'h80000000, 64'h0463_0001_0001_0001);
        q.push_back(mk({32'h0, 32'h1, 32'h1, 32'h1}, 4'b0111, 4'b0111, 0, 0, 0, 0, 0,
                       0, 0, '0, 39'h80000000));
        @(negedge clk);
        check_front(1);
        bus.scan_ready_and_i = 1'b0;
        bus.redirect_i       = 1'b1;
        bus.fetch_pc_i       = 39'h80000008;
        bus.fetch_data_i     = 64'h0001_0001_0001_0000;
        #1;
        chk("redirect_ready", 128'(bus.fetch_ready_and_o), 128'd0);
        @(negedge clk);
        bus.redirect_i       = 1'b0;
        bus.fetch_v_i        = 1'b0;
        bus.scan_ready_and_i = 1'b1;
        chk("redirect_scan_v", 128'(bus.scan_v_o), 128'd0);
        drive(39'h80000008, 64'h0001_0001_0001_0000);
        q.push_back(mk(NOP3Z, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, '0, 39'h80000008));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // Residual with PC mismatch is discarded
        @(negedge clk);
        drive(39'h80000000, 64'h0463_0001_0001_0001);
        q.push_back(mk({32'h0, 32'h1, 32'h1, 32'h1}, 4'b0111, 4'b0111, 0, 0, 0, 0, 0,
                       0, 0, '0, 39'h80000000));
        @(negedge clk);
        check_front(1);
        drive(39'h80000100, 64'h0001_0001_0001_0001);
        q.push_back(mk(NOP4, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, '0, 39'h80000100));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);

        // Backpressure for 3 cycles, then asynchronous reset mid-stall
        @(negedge clk);
        bus.scan_ready_and_i = 1'b0;
        drive(39'h80000000, 64'h0463_0001_0001_0001);
        q.push_back(mk({32'h0, 32'h1, 32'h1, 32'h1}, 4'b0111, 4'b0111, 0, 0, 0, 0, 0,
                       0, 0, '0, 39'h80000000));
        @(negedge clk);
        bus.fetch_pc_i   = 39'h80000008;
        bus.fetch_data_i = 64'h0001_0001_0001_0000;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check_front(0);
            #1;
            chk("stall_ready", 128'(bus.fetch_ready_and_o), 128'd0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        void'(q.pop_front());
        bus.fetch_v_i        = 1'b0;
        bus.scan_ready_and_i = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        // Residual must not survive reset
        drive(39'h80000008, 64'h0001_0001_0001_0000);
        q.push_back(mk(NOP3Z, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, '0, 39'h80000008));
        @(negedge clk);
        bus.fetch_v_i = 1'b0;
        check_front(1);
        @(negedge clk);
        chk("idle_scan_v", 128'(bus.scan_v_o), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
